// File: rtl/tube_write_arbiter_pkg.sv
// Shared constants for the tube write arbiter: FSM state encoding and
// the tube peripheral register map.
package tube_write_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_DATA = 2'd1,
    ST_WR_SIGN = 2'd2,
    ST_VERIFY  = 2'd3
  } state_e;

  localparam logic TUBE_ADDR_VALUE = 1'b0;
  localparam logic TUBE_ADDR_SIGN  = 1'b1;

endpackage

// File: rtl/tube_write_arbiter.sv
// Round-robin arbiter that turns one accepted requester update into a
// value write, a sign write and an optional readback check on the tube.
module tube_write_arbiter
  import tube_write_arbiter_pkg::*;
#(
  parameter bit VERIFY_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic [31:0] req0_data,
  input  logic [31:0] req1_data,
  input  logic [3:0]  req0_sign,
  input  logic [3:0]  req1_sign,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic        tube_we,
  output logic        tube_addr,
  output logic [31:0] tube_din,
  input  logic [31:0] tube_rd,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        last_grant,
  output state_e      dbg_state
);

  // Handshake: a requester's update is accepted in any cycle where its
  // valid and ready are both high; ready is only ever high in IDLE, for the
  // granted requester, and never while reset is asserted.

  state_e      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  sign_q, sign_d;
  logic        last_grant_q, last_grant_d;
  logic        err_q, err_d;
  logic        grant;

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    sign_d       = sign_q;
    last_grant_d = last_grant_q;
    err_d        = err_q;
    grant        = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    tube_we      = 1'b0;
    tube_addr    = TUBE_ADDR_VALUE;
    tube_din     = 32'd0;
    done         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // With both pending, the requester not served last goes next.
        if (req0_valid && req1_valid) grant = ~last_grant_q;
        else                          grant = req1_valid;
        if (!reset && (req0_valid || req1_valid)) begin
          req0_ready   = ~grant;
          req1_ready   = grant;
          data_d       = grant ? req1_data : req0_data;
          sign_d       = grant ? req1_sign : req0_sign;
          last_grant_d = grant;
          state_d      = ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        tube_we   = 1'b1;
        tube_addr = TUBE_ADDR_VALUE;
        tube_din  = data_q;
        state_d   = ST_WR_SIGN;
      end
      ST_WR_SIGN: begin
        tube_we   = 1'b1;
        tube_addr = TUBE_ADDR_SIGN;
        tube_din  = {28'd0, sign_q};
        if (VERIFY_EN) begin
          state_d = ST_VERIFY;
        end else begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_VERIFY: begin
        done = 1'b1;
        if (tube_rd != data_q) err_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      data_q       <= 32'd0;
      sign_q       <= 4'd0;
      last_grant_q <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      sign_q       <= sign_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign err        = err_q;
  assign last_grant = last_grant_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_tube_write_arbiter.sv
// Directed bench for tube_write_arbiter: a verifying instance with a small
// tube peripheral model, plus a VERIFY_EN=0 instance.
module tb_tube_write_arbiter;
  import tube_write_arbiter_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        req0_valid = 0, req1_valid = 0;
  logic [31:0] req0_data = 0, req1_data = 0;
  logic [3:0]  req0_sign = 0, req1_sign = 0;
  logic        req0_ready, req1_ready, tube_we, tube_addr, busy, done, err, last_grant;
  logic [31:0] tube_din, tube_rd;
  state_e      dbg_state;

  logic        nv_req0_valid = 0, nv_req1_valid = 0;
  logic [31:0] nv_req0_data = 0, nv_req1_data = 0;
  logic [3:0]  nv_req0_sign = 0, nv_req1_sign = 0;
  logic        nv_req0_ready, nv_req1_ready, nv_tube_we, nv_tube_addr;
  logic        nv_busy, nv_done, nv_err, nv_last_grant;
  logic [31:0] nv_tube_din;
  state_e      nv_dbg_state;

  int checks = 0;
  int errors = 0;

  // tube peripheral model and write scoreboard
  logic [31:0] periph_val = 32'd0;
  logic        force_bad = 1'b0;
  logic [32:0] wr_q[$];
  logic [32:0] exp_q[$];
  assign tube_rd = force_bad ? 32'hDEADBEEF : periph_val;

  always @(posedge clk) begin
    if (tube_we) begin
      wr_q.push_back({tube_addr, tube_din});
      if (tube_addr == TUBE_ADDR_VALUE) periph_val <= tube_din;
    end
  end

  tube_write_arbiter #(.VERIFY_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_sign(req0_sign), .req1_sign(req1_sign),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .tube_we(tube_we), .tube_addr(tube_addr), .tube_din(tube_din), .tube_rd(tube_rd),
    .busy(busy), .done(done), .err(err), .last_grant(last_grant), .dbg_state(dbg_state)
  );

  tube_write_arbiter #(.VERIFY_EN(1'b0)) u_dut_nv (
    .clk(clk), .reset(reset),
    .req0_valid(nv_req0_valid), .req1_valid(nv_req1_valid),
    .req0_data(nv_req0_data), .req1_data(nv_req1_data),
    .req0_sign(nv_req0_sign), .req1_sign(nv_req1_sign),
    .req0_ready(nv_req0_ready), .req1_ready(nv_req1_ready),
    .tube_we(nv_tube_we), .tube_addr(nv_tube_addr), .tube_din(nv_tube_din), .tube_rd(32'd0),
    .busy(nv_busy), .done(nv_done), .err(nv_err), .last_grant(nv_last_grant),
    .dbg_state(nv_dbg_state)
  );

  task automatic test_reset;
    reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b exp 0", busy); end
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0b%0b exp 00", req0_ready, req1_ready); end
    checks++; if (tube_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %0b exp 0", tube_we); end
    checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_done_err: got %0b%0b exp 00", done, err); end
    checks++; if (last_grant !== 1'b1) begin errors++; $display("FAIL rst_last_grant: got %0b exp 1", last_grant); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d exp %0d", dbg_state, ST_IDLE); end
    checks++; if (nv_last_grant !== 1'b1 || nv_busy !== 1'b0) begin errors++; $display("FAIL rst_nv: got lg=%0b busy=%0b exp lg=1 busy=0", nv_last_grant, nv_busy); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single;
    wr_q.delete(); exp_q.delete();
    exp_q.push_back({1'b0, 32'h12345678});
    exp_q.push_back({1'b1, 32'h00000001});
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 32'h12345678; req0_sign = 4'h1;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready: got %0b%0b exp 10", req0_ready, req1_ready); end
    @(negedge clk); req0_valid = 1'b0; #1;
    checks++; if (tube_we !== 1'b1 || tube_addr !== 1'b0 || tube_din !== 32'h12345678) begin errors++; $display("FAIL single_wr_data: got we=%0b a=%0b d=%h exp we=1 a=0 d=12345678", tube_we, tube_addr, tube_din); end
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL single_busy: got busy=%0b done=%0b exp 1 0", busy, done); end
    @(negedge clk); #1;
    checks++; if (tube_we !== 1'b1 || tube_addr !== 1'b1 || tube_din !== 32'h00000001) begin errors++; $display("FAIL single_wr_sign: got we=%0b a=%0b d=%h exp we=1 a=1 d=00000001", tube_we, tube_addr, tube_din); end
    @(negedge clk); #1;
    checks++; if (done !== 1'b1 || tube_we !== 1'b0 || tube_din !== 32'd0) begin errors++; $display("FAIL single_verify: got done=%0b we=%0b d=%h exp done=1 we=0 d=0", done, tube_we, tube_din); end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || last_grant !== 1'b0) begin errors++; $display("FAIL single_end: got busy=%0b done=%0b err=%0b lg=%0b exp 0 0 0 0", busy, done, err, last_grant); end
    checks++; if (wr_q.size() !== exp_q.size()) begin errors++; $display("FAIL single_log_len: got %0d exp %0d", wr_q.size(), exp_q.size()); end
    else for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (wr_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_log[%0d]: got %h exp %h", i, wr_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_round_robin;
    logic exp_g;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    req0_valid = 1'b1; req0_data = 32'hA0A00000; req0_sign = 4'h3;
    req1_valid = 1'b1; req1_data = 32'hB1B10001; req1_sign = 4'h4;
    exp_g = 1'b0;
    for (int n = 0; n < 4; n++) begin
      #1;
      checks++; if (req0_ready !== ~exp_g || req1_ready !== exp_g) begin errors++; $display("FAIL rr_ready[%0d]: got %0b%0b exp grant %0b", n, req0_ready, req1_ready, exp_g); end
      @(negedge clk); #1;
      checks++; if (last_grant !== exp_g) begin errors++; $display("FAIL rr_last_grant[%0d]: got %0b exp %0b", n, last_grant, exp_g); end
      checks++; if (tube_din !== (exp_g ? 32'hB1B10001 : 32'hA0A00000)) begin errors++; $display("FAIL rr_din[%0d]: got %h exp grant %0b data", n, tube_din, exp_g); end
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL rr_busy_ready[%0d]: got %0b%0b exp 00", n, req0_ready, req1_ready); end
      repeat (2) @(negedge clk);
      #1;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL rr_done[%0d]: got %0b exp 1", n, done); end
      @(negedge clk);
      exp_g = ~exp_g;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rr_err: got %0b exp 0", err); end
  endtask

  task automatic test_verify_err;
    @(negedge clk);
    force_bad = 1'b1;
    req0_valid = 1'b1; req0_data = 32'h00000005; req0_sign = 4'h0;
    @(negedge clk); req0_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL verr_set: got err=%0b busy=%0b exp 1 0", err, busy); end
    force_bad = 1'b0;
    req1_valid = 1'b1; req1_data = 32'h00000007; req1_sign = 4'h2;
    @(negedge clk); req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (err !== 1'b1 || last_grant !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL verr_sticky: got err=%0b lg=%0b busy=%0b exp 1 1 0", err, last_grant, busy); end
  endtask

  task automatic test_reset_mid;
    wr_q.delete(); exp_q.delete();
    exp_q.push_back({1'b0, 32'h000055AA});
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 32'h000055AA; req0_sign = 4'h9;
    @(negedge clk); req0_valid = 1'b0; #1;
    checks++; if (tube_we !== 1'b1 || tube_addr !== 1'b0) begin errors++; $display("FAIL rmid_wr_data: got we=%0b a=%0b exp 1 0", tube_we, tube_addr); end
    reset = 1'b1;
    @(negedge clk); #1;
    checks++; if (tube_we !== 1'b0 || busy !== 1'b0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL rmid_abort: got we=%0b busy=%0b st=%0d exp 0 0 0", tube_we, busy, dbg_state); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rmid_err_clear: got %0b exp 0", err); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (wr_q.size() !== exp_q.size()) begin errors++; $display("FAIL rmid_log_len: got %0d exp %0d", wr_q.size(), exp_q.size()); end
    else if (wr_q[0] !== exp_q[0]) begin errors++; $display("FAIL rmid_log: got %h exp %h", wr_q[0], exp_q[0]); end
  endtask

  task automatic test_no_verify;
    @(negedge clk);
    nv_req1_valid = 1'b1; nv_req1_data = 32'hFFFFFFFF; nv_req1_sign = 4'hE;
    #1;
    checks++; if (nv_req1_ready !== 1'b1 || nv_req0_ready !== 1'b0) begin errors++; $display("FAIL nv_ready: got %0b%0b exp 01", nv_req0_ready, nv_req1_ready); end
    @(negedge clk); nv_req1_valid = 1'b0; #1;
    checks++; if (nv_tube_we !== 1'b1 || nv_tube_addr !== 1'b0 || nv_tube_din !== 32'hFFFFFFFF || nv_done !== 1'b0) begin errors++; $display("FAIL nv_wr_data: got we=%0b a=%0b d=%h done=%0b exp 1 0 ffffffff 0", nv_tube_we, nv_tube_addr, nv_tube_din, nv_done); end
    @(negedge clk); #1;
    checks++; if (nv_tube_we !== 1'b1 || nv_tube_addr !== 1'b1 || nv_tube_din !== 32'h0000000E || nv_done !== 1'b1) begin errors++; $display("FAIL nv_wr_sign: got we=%0b a=%0b d=%h done=%0b exp 1 1 0000000e 1", nv_tube_we, nv_tube_addr, nv_tube_din, nv_done); end
    @(negedge clk); #1;
    checks++; if (nv_busy !== 1'b0 || nv_done !== 1'b0 || nv_tube_we !== 1'b0 || nv_last_grant !== 1'b1 || nv_err !== 1'b0) begin errors++; $display("FAIL nv_end: got busy=%0b done=%0b we=%0b lg=%0b err=%0b exp 0 0 0 1 0", nv_busy, nv_done, nv_tube_we, nv_last_grant, nv_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_verify_err();
    test_reset_mid();
    test_no_verify();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tube_write_arbiter.md
TUBE_WRITE_ARBITER -- requirements
Module: tube_write_arbiter

Interface
REQ-001 SHALL have parameter VERIFY_EN, default 1, meaning 1 enables the readback-check state after each update.
REQ-002 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  reset: synchronous, active-high.
REQ-004 SHALL have ports req0_valid  input  1  and req1_valid  input  1; each means that requester has an update pending.
REQ-005 SHALL have ports req0_data  input  32  and req1_data  input  32; each is the value to display.
REQ-006 SHALL have ports req0_sign  input  4  and req1_sign  input  4; each is the sign-digit code.
REQ-007 SHALL have ports req0_ready  output  1  and req1_ready  output  1; each means the update is accepted this cycle.
REQ-008 SHALL have port tube_we  output  1  write enable to the tube peripheral.
REQ-009 SHALL have port tube_addr  output  1  peripheral register select: 0 is the value, 1 is the sign.
REQ-010 SHALL have port tube_din  output  32  write data to the tube peripheral.
REQ-011 SHALL have port tube_rd  input  32  combinational readback from the tube peripheral.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse when an update sequence ends.
REQ-014 SHALL have port err  output  1  sticky flag set on readback mismatch.
REQ-015 SHALL have port last_grant  output  1  index of the most recently accepted requester.

Function
REQ-016 SHALL implement the FSM states IDLE, WR_DATA, WR_SIGN and VERIFY.
REQ-017 SHALL, in IDLE, assert ready combinationally only for the granted requester; handshake = valid & ready.
REQ-018 SHALL, in IDLE, grant the single valid requester; when both are valid, grant the one != last_grant (round-robin).
REQ-019 SHALL, on handshake, latch data/sign, update last_grant and move to WR_DATA the next cycle.
REQ-020 SHALL, in WR_DATA, drive tube_we=1, tube_addr=0, tube_din=latched data for exactly one cycle, then go to WR_SIGN.
REQ-021 SHALL, in WR_SIGN, drive tube_we=1, tube_addr=1, tube_din={28'b0, latched sign} for one cycle; next state is VERIFY if VERIFY_EN=1, else IDLE.
REQ-022 SHALL, in VERIFY, drive tube_we=0, tube_addr=0, compare tube_rd to latched data, set err on mismatch, then go to IDLE.
REQ-023 SHALL pulse done in the final state of a sequence (VERIFY, or WR_SIGN when VERIFY_EN=0).
REQ-024 SHALL drive tube_we=0, tube_addr=0, tube_din=0 and both ready=0 in every state other than those specified above.
REQ-025 SHALL ignore valid while busy; requests stay pending until accepted, with no queueing.
REQ-026 SHALL give a minimum cycle count per update of 3 (VERIFY_EN=0) or 4 (VERIFY_EN=1), counting the handshake cycle through the IDLE return.
REQ-027 SHALL keep err set until reset; a new sequence does not clear it.

Reset
REQ-028 SHALL, on reset, set state=IDLE, last_grant=1 (req0 wins the first contention), err=0, done=0 and latched data/sign=0.
REQ-029 SHALL, on reset mid-sequence, abort immediately with tube_we=0 in the following cycle and no partial sign write.
REQ-030 SHALL take reset priority over any simultaneous handshake.

Structure
REQ-031 SHALL place the FSM state encodings and the peripheral register addresses (value=0, sign=1) as shared constants in the package.
REQ-032 SHALL have no sub-module; the tube peripheral is instantiated alongside this block by the bridge, not inside it.

Verification
REQ-033 SHALL cover this scenario: req0 only, data=0x12345678, sign=0x1 -> tube writes (addr0,0x12345678) then (addr1,0x00000001), done after 4 cycles, err=0.
REQ-034 SHALL cover this scenario: req0 and req1 both valid from reset -> req0 granted first, req1 next; last_grant sequence 0,1.
REQ-035 SHALL cover this scenario: both held valid for 4 updates -> grants alternate 0,1,0,1 and no requester is starved.
REQ-036 SHALL cover this scenario: tube_rd forced to 0xDEADBEEF while writing 0x00000005 -> err=1 after VERIFY and stays 1 across the next good update.
REQ-037 SHALL cover this scenario: reset asserted during WR_DATA -> no addr1 write occurs, state=IDLE, busy=0 the next cycle.
REQ-038 SHALL cover this scenario: VERIFY_EN=0, req1 data=0xFFFFFFFF, sign=0xE -> two writes, done in the WR_SIGN cycle, 3-cycle sequence.
